// File: rtl/gpcfg_arb.sv
// Two-master arbiter in front of a config register bank: one access per
// IDLE -> ACCESS -> RESP round, round-robin or fixed-priority on ties.
module gpcfg_arb #(
    parameter int PRIO_FIXED = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        cfg_wr_en,
    output logic        cfg_rd_en,
    output logic [3:0]  cfg_byte_en,
    output logic [31:0] cfg_wr_addr,
    output logic [31:0] cfg_rd_addr,
    output logic [31:0] cfg_wdata,
    input  logic [31:0] cfg_rdata,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]  state_reg, state_next;
    logic        gnt_reg, last_gnt_reg, we_reg;
    logic [31:0] addr_reg, wdata_reg;
    logic [3:0]  be_reg;
    logic        gnt_next, take, in_access;
    wire  [1:0]  ack_vec;
    wire  [31:0] rdata_vec [2];

    assign take      = (state_reg == ST_IDLE) && (m0_req || m1_req);
    assign in_access = (state_reg == ST_ACCESS);

    // last_gnt resets to 1 so that requester 0 wins the first tie.
    always_comb begin
        gnt_next = 1'b0;
        if (m0_req && m1_req)
            gnt_next = (PRIO_FIXED != 0) ? 1'b0 : ~last_gnt_reg;
        else if (m1_req)
            gnt_next = 1'b1;
    end

    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_IDLE:   state_next = take ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_next = ST_RESP;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_reg    <= ST_IDLE;
            gnt_reg      <= 1'b0;
            last_gnt_reg <= 1'b1;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            be_reg       <= '0;
            wdata_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (take) begin
                gnt_reg      <= gnt_next;
                last_gnt_reg <= gnt_next;
                we_reg       <= gnt_next ? m1_we    : m0_we;
                addr_reg     <= gnt_next ? m1_addr  : m0_addr;
                be_reg       <= gnt_next ? m1_be    : m0_be;
                wdata_reg    <= gnt_next ? m1_wdata : m0_wdata;
            end
        end
    end

    // Per-requester read-data holding register and ack decode.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            logic [31:0] rdata_reg;
            always_ff @(posedge hclk or negedge hresetn) begin
                if (!hresetn)
                    rdata_reg <= '0;
                else if (in_access && !we_reg && (gnt_reg == 1'(gi)))
                    rdata_reg <= cfg_rdata;
            end
            assign rdata_vec[gi] = rdata_reg;
            assign ack_vec[gi]   = (state_reg == ST_RESP) && (gnt_reg == 1'(gi));
        end
    endgenerate

    assign m0_ack      = ack_vec[0];
    assign m1_ack      = ack_vec[1];
    assign m0_rdata    = rdata_vec[0];
    assign m1_rdata    = rdata_vec[1];
    assign cfg_wr_en   = in_access && we_reg;
    assign cfg_rd_en   = in_access && !we_reg;
    assign cfg_byte_en = (in_access && we_reg) ? be_reg : 4'h0;
    assign cfg_wr_addr = addr_reg;
    assign cfg_rd_addr = addr_reg;
    assign cfg_wdata   = wdata_reg;
    assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_gpcfg_arb.sv
// Bench for gpcfg_arb: instance 0 round-robin, instance 1 fixed priority,
// each with its own register bank and transaction-level reference model.
module tb_gpcfg_arb;

    logic hclk, hresetn, bank_clr;
    logic [1:0]  req   [2];
    logic [1:0]  we    [2];
    logic [31:0] addr  [2][2];
    logic [3:0]  be    [2][2];
    logic [31:0] wdata [2][2];

    wire         ack_w         [2][2];
    wire  [31:0] rdata_w       [2][2];
    wire         cfg_wr_en_w   [2];
    wire         cfg_rd_en_w   [2];
    wire  [3:0]  cfg_byte_en_w [2];
    wire  [31:0] cfg_wr_addr_w [2];
    wire  [31:0] cfg_rd_addr_w [2];
    wire  [31:0] cfg_wdata_w   [2];
    wire  [31:0] cfg_rdata_w   [2];
    wire         busy_w        [2];

    int n_vec = 0;
    int n_err = 0;

    int          last_gnt [2];
    logic [31:0] ref_mem  [2][16];
    logic [31:0] exp_rd   [2][2];

    function automatic logic [31:0] init_word(input int i);
        return (i == 8) ? 32'h12345678 : ({4{8'(i)}} ^ 32'hC3A50F96);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] bes);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (bes[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // {busy, wr_en, rd_en, byte_en, m0_ack, m1_ack}
    function automatic logic [8:0] stat(input int k);
        return {busy_w[k], cfg_wr_en_w[k], cfg_rd_en_w[k], cfg_byte_en_w[k], ack_w[k][0], ack_w[k][1]};
    endfunction

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            logic [31:0] bank [16];

            gpcfg_arb #(.PRIO_FIXED(gi)) u_dut (
                .hclk        (hclk),
                .hresetn     (hresetn),
                .m0_req      (req[gi][0]),
                .m0_we       (we[gi][0]),
                .m0_addr     (addr[gi][0]),
                .m0_be       (be[gi][0]),
                .m0_wdata    (wdata[gi][0]),
                .m0_ack      (ack_w[gi][0]),
                .m0_rdata    (rdata_w[gi][0]),
                .m1_req      (req[gi][1]),
                .m1_we       (we[gi][1]),
                .m1_addr     (addr[gi][1]),
                .m1_be       (be[gi][1]),
                .m1_wdata    (wdata[gi][1]),
                .m1_ack      (ack_w[gi][1]),
                .m1_rdata    (rdata_w[gi][1]),
                .cfg_wr_en   (cfg_wr_en_w[gi]),
                .cfg_rd_en   (cfg_rd_en_w[gi]),
                .cfg_byte_en (cfg_byte_en_w[gi]),
                .cfg_wr_addr (cfg_wr_addr_w[gi]),
                .cfg_rd_addr (cfg_rd_addr_w[gi]),
                .cfg_wdata   (cfg_wdata_w[gi]),
                .cfg_rdata   (cfg_rdata_w[gi]),
                .busy        (busy_w[gi])
            );

            assign cfg_rdata_w[gi] = bank[cfg_rd_addr_w[gi][5:2]];

            always @(posedge hclk) begin
                if (bank_clr) begin
                    for (int i = 0; i < 16; i++) bank[i] <= init_word(i);
                end else if (cfg_wr_en_w[gi]) begin
                    bank[cfg_wr_addr_w[gi][5:2]] <= merge(bank[cfg_wr_addr_w[gi][5:2]],
                                                          cfg_wdata_w[gi], cfg_byte_en_w[gi]);
                end
            end
        end
    endgenerate

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs;
        for (int k = 0; k < 2; k++) begin
            req[k] = 2'b00;
            we[k]  = 2'b00;
            for (int m = 0; m < 2; m++) begin
                addr[k][m]  = '0;
                be[k][m]    = '0;
                wdata[k][m] = '0;
            end
        end
    endtask

    task automatic test_reset;
        hresetn  = 1'b0;
        bank_clr = 1'b1;
        clear_inputs();
        req[0] = 2'b11;
        req[1] = 2'b11;
        repeat (3) @(posedge hclk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if ({stat(k), cfg_wr_addr_w[k], cfg_rd_addr_w[k], cfg_wdata_w[k], rdata_w[k][0], rdata_w[k][1]} !== '0) begin
                n_err++;
                $display("FAIL reset_state k=%0d got stat=%b wa=%h ra=%h wd=%h rd0=%h rd1=%h expected all zero",
                         k, stat(k), cfg_wr_addr_w[k], cfg_rd_addr_w[k], cfg_wdata_w[k], rdata_w[k][0], rdata_w[k][1]);
            end
            last_gnt[k] = 1;
            exp_rd[k][0] = '0;
            exp_rd[k][1] = '0;
            for (int i = 0; i < 16; i++) ref_mem[k][i] = init_word(i);
        end
        // Release mid-cycle; the caller presents its request at the same instant.
        @(negedge hclk);
        clear_inputs();
        hresetn  = 1'b1;
        bank_clr = 1'b0;
    endtask

    task automatic test_single_write;
        for (int k = 0; k < 2; k++) begin
            req[k] = 2'b01; we[k][0] = 1'b1; addr[k][0] = 32'h10;
            be[k][0] = 4'b0101; wdata[k][0] = 32'hAABBCCDD;
        end
        @(posedge hclk); #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if ({stat(k), cfg_wr_addr_w[k], cfg_wdata_w[k]} !== {9'b1_1_0_0101_0_0, 32'h10, 32'hAABBCCDD}) begin
                n_err++;
                $display("FAIL wr_access k=%0d got stat=%b wa=%h wd=%h expected stat=110010100 wa=10 wd=aabbccdd",
                         k, stat(k), cfg_wr_addr_w[k], cfg_wdata_w[k]);
            end
            ref_mem[k][4] = merge(ref_mem[k][4], 32'hAABBCCDD, 4'b0101);
            last_gnt[k] = 0;
        end
        @(posedge hclk); #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if ({stat(k), rdata_w[k][0], rdata_w[k][1]} !== {9'b1_0_0_0000_1_0, exp_rd[k][0], exp_rd[k][1]}) begin
                n_err++;
                $display("FAIL wr_resp k=%0d got stat=%b rd0=%h rd1=%h expected stat=100000010 rd0=%h rd1=%h",
                         k, stat(k), rdata_w[k][0], rdata_w[k][1], exp_rd[k][0], exp_rd[k][1]);
            end
            req[k] = 2'b00;
        end
        @(posedge hclk); #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if ({stat(k), cfg_wr_addr_w[k], cfg_wdata_w[k]} !== {9'b0, 32'h10, 32'hAABBCCDD}) begin
                n_err++;
                $display("FAIL wr_idle_hold k=%0d got stat=%b wa=%h wd=%h expected stat=0 wa=10 wd=aabbccdd",
                         k, stat(k), cfg_wr_addr_w[k], cfg_wdata_w[k]);
            end
        end
    endtask

    task automatic test_single_read;
        for (int k = 0; k < 2; k++) begin
            req[k] = 2'b10; we[k][1] = 1'b0; addr[k][1] = 32'h20;
        end
        @(posedge hclk); #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if ({stat(k), cfg_rd_addr_w[k]} !== {9'b1_0_1_0000_0_0, 32'h20}) begin
                n_err++;
                $display("FAIL rd_access k=%0d got stat=%b ra=%h expected stat=101000000 ra=20",
                         k, stat(k), cfg_rd_addr_w[k]);
            end
            exp_rd[k][1] = 32'h12345678;
            last_gnt[k] = 1;
        end
        @(posedge hclk); #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if ({stat(k), rdata_w[k][0], rdata_w[k][1]} !== {9'b1_0_0_0000_0_1, exp_rd[k][0], 32'h12345678}) begin
                n_err++;
                $display("FAIL rd_resp k=%0d got stat=%b rd0=%h rd1=%h expected stat=100000001 rd0=%h rd1=12345678",
                         k, stat(k), rdata_w[k][0], rdata_w[k][1], exp_rd[k][0]);
            end
            req[k] = 2'b00;
        end
        @(posedge hclk); #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (stat(k) !== 9'b0) begin
                n_err++;
                $display("FAIL rd_idle k=%0d got stat=%b expected 0", k, stat(k));
            end
        end
    endtask

    // Both masters hold req for four accesses; instance 1 is fixed priority.
    task automatic test_round_robin;
        int g;
        for (int k = 0; k < 2; k++) begin
            req[k] = 2'b11; we[k] = 2'b00; addr[k][0] = 32'h0; addr[k][1] = 32'h4;
        end
        for (int a = 0; a < 4; a++) begin
            @(posedge hclk); #1;
            for (int k = 0; k < 2; k++) begin
                g = (k == 1) ? 0 : (a % 2);
                n_vec++;
                if ({stat(k), cfg_rd_addr_w[k]} !== {9'b1_0_1_0000_0_0, addr[k][g]}) begin
                    n_err++;
                    $display("FAIL rr_access k=%0d a=%0d got stat=%b ra=%h expected stat=101000000 ra=%h",
                             k, a, stat(k), cfg_rd_addr_w[k], addr[k][g]);
                end
                last_gnt[k] = g;
                exp_rd[k][g] = ref_mem[k][addr[k][g][5:2]];
            end
            @(posedge hclk); #1;
            for (int k = 0; k < 2; k++) begin
                g = (k == 1) ? 0 : (a % 2);
                n_vec++;
                if ({stat(k), rdata_w[k][0], rdata_w[k][1]} !==
                    {7'b1_0_0_0000, g == 0, g == 1, exp_rd[k][0], exp_rd[k][1]}) begin
                    n_err++;
                    $display("FAIL rr_resp k=%0d a=%0d got stat=%b rd0=%h rd1=%h expected ack_m%0d rd0=%h rd1=%h",
                             k, a, stat(k), rdata_w[k][0], rdata_w[k][1], g, exp_rd[k][0], exp_rd[k][1]);
                end
                if (a == 3) req[k] = 2'b00;
            end
            @(posedge hclk); #1;
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (stat(k) !== 9'b0) begin
                    n_err++;
                    $display("FAIL rr_idle k=%0d a=%0d got stat=%b expected 0", k, a, stat(k));
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a_w, d_w;
        logic [3:0]  b_w;
        a_w = $urandom; d_w = $urandom; b_w = 4'($urandom_range(1, 15));
        for (int k = 0; k < 2; k++) begin
            req[k] = 2'b01; we[k][0] = 1'b1; addr[k][0] = a_w; be[k][0] = b_w; wdata[k][0] = d_w;
        end
        for (int a = 0; a < 4; a++) begin
            @(posedge hclk); #1;
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if ({stat(k), cfg_wr_addr_w[k], cfg_wdata_w[k]} !== {3'b110, be[k][0], 2'b00, addr[k][0], wdata[k][0]}) begin
                    n_err++;
                    $display("FAIL b2b_access k=%0d a=%0d got stat=%b wa=%h wd=%h expected be=%b wa=%h wd=%h",
                             k, a, stat(k), cfg_wr_addr_w[k], cfg_wdata_w[k], be[k][0], addr[k][0], wdata[k][0]);
                end
                ref_mem[k][addr[k][0][5:2]] = merge(ref_mem[k][addr[k][0][5:2]], wdata[k][0], be[k][0]);
                last_gnt[k] = 0;
            end
            @(posedge hclk); #1;
            a_w = $urandom; d_w = $urandom; b_w = 4'($urandom_range(1, 15));
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (stat(k) !== 9'b1_0_0_0000_1_0) begin
                    n_err++;
                    $display("FAIL b2b_resp k=%0d a=%0d got stat=%b expected 100000010", k, a, stat(k));
                end
                addr[k][0] = a_w; be[k][0] = b_w; wdata[k][0] = d_w;
                if (a == 3) req[k] = 2'b00;
            end
            @(posedge hclk); #1;
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (stat(k) !== 9'b0) begin
                    n_err++;
                    $display("FAIL b2b_idle k=%0d a=%0d got stat=%b expected 0", k, a, stat(k));
                end
            end
        end
    endtask

    task automatic test_reset_mid_access;
        for (int k = 0; k < 2; k++) begin
            req[k] = 2'b01; we[k][0] = 1'b1; addr[k][0] = 32'h14; be[k][0] = 4'hF; wdata[k][0] = 32'hDEADBEEF;
        end
        @(posedge hclk); #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (stat(k) !== 9'b1_1_0_1111_0_0) begin
                n_err++;
                $display("FAIL rst_pre_access k=%0d got stat=%b expected 110111100", k, stat(k));
            end
        end
        hresetn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if ({stat(k), cfg_wr_addr_w[k], cfg_rd_addr_w[k], cfg_wdata_w[k], rdata_w[k][0], rdata_w[k][1]} !== '0) begin
                n_err++;
                $display("FAIL rst_async k=%0d got stat=%b wa=%h ra=%h wd=%h rd0=%h rd1=%h expected all zero",
                         k, stat(k), cfg_wr_addr_w[k], cfg_rd_addr_w[k], cfg_wdata_w[k], rdata_w[k][0], rdata_w[k][1]);
            end
            last_gnt[k] = 1;
            exp_rd[k][0] = '0;
            exp_rd[k][1] = '0;
            req[k] = 2'b00;
        end
        repeat (2) begin
            @(posedge hclk); #1;
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (stat(k) !== 9'b0) begin
                    n_err++;
                    $display("FAIL rst_no_ack k=%0d got stat=%b expected 0", k, stat(k));
                end
            end
        end
        @(negedge hclk);
        hresetn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req[k] = 2'b11; we[k] = 2'b00; addr[k][0] = 32'h14; addr[k][1] = 32'h18;
        end
        @(posedge hclk); #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if ({stat(k), cfg_rd_addr_w[k]} !== {9'b1_0_1_0000_0_0, 32'h14}) begin
                n_err++;
                $display("FAIL rst_first_tie k=%0d got stat=%b ra=%h expected stat=101000000 ra=14",
                         k, stat(k), cfg_rd_addr_w[k]);
            end
            last_gnt[k] = 0;
            exp_rd[k][0] = ref_mem[k][5];
        end
        @(posedge hclk); #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if ({stat(k), rdata_w[k][0]} !== {9'b1_0_0_0000_1_0, exp_rd[k][0]}) begin
                n_err++;
                $display("FAIL rst_first_resp k=%0d got stat=%b rd0=%h expected stat=100000010 rd0=%h",
                         k, stat(k), rdata_w[k][0], exp_rd[k][0]);
            end
            req[k] = 2'b00;
        end
        @(posedge hclk); #1;
    endtask

    // Random traffic: req doubles as the pending flag; losers stay asserted.
    task automatic test_random;
        int g [2];
        logic [8:0] e;
        for (int s = 0; s < 150; s++) begin
            for (int k = 0; k < 2; k++) begin
                for (int m = 0; m < 2; m++) begin
                    if (!req[k][m] && $urandom_range(0, 2) != 0) begin
                        req[k][m]   = 1'b1;
                        we[k][m]    = 1'($urandom_range(0, 1));
                        addr[k][m]  = $urandom;
                        be[k][m]    = 4'($urandom_range(0, 15));
                        wdata[k][m] = $urandom;
                    end
                end
                if (req[k] == 2'b11)      g[k] = (k == 1) ? 0 : 1 - last_gnt[k];
                else if (req[k] == 2'b01) g[k] = 0;
                else if (req[k] == 2'b10) g[k] = 1;
                else                      g[k] = -1;
            end
            @(posedge hclk); #1;
            for (int k = 0; k < 2; k++) begin
                if (g[k] >= 0) begin
                    e = {1'b1, we[k][g[k]], ~we[k][g[k]], we[k][g[k]] ? be[k][g[k]] : 4'h0, 2'b00};
                    n_vec++;
                    if ({stat(k), cfg_wr_addr_w[k], cfg_rd_addr_w[k], cfg_wdata_w[k]} !==
                        {e, addr[k][g[k]], addr[k][g[k]], wdata[k][g[k]]}) begin
                        n_err++;
                        $display("FAIL rnd_access k=%0d s=%0d got stat=%b wa=%h ra=%h wd=%h expected stat=%b addr=%h wd=%h",
                                 k, s, stat(k), cfg_wr_addr_w[k], cfg_rd_addr_w[k], cfg_wdata_w[k],
                                 e, addr[k][g[k]], wdata[k][g[k]]);
                    end
                    last_gnt[k] = g[k];
                    if (we[k][g[k]])
                        ref_mem[k][addr[k][g[k]][5:2]] = merge(ref_mem[k][addr[k][g[k]][5:2]], wdata[k][g[k]], be[k][g[k]]);
                    else
                        exp_rd[k][g[k]] = ref_mem[k][addr[k][g[k]][5:2]];
                    if ($urandom_range(0, 1) == 1) req[k][g[k]] = 1'b0;
                end else begin
                    n_vec++;
                    if (stat(k) !== 9'b0) begin
                        n_err++;
                        $display("FAIL rnd_noreq k=%0d s=%0d got stat=%b expected 0", k, s, stat(k));
                    end
                end
            end
            @(posedge hclk); #1;
            for (int k = 0; k < 2; k++) begin
                e = (g[k] >= 0) ? {7'b1_0_0_0000, g[k] == 0, g[k] == 1} : 9'b0;
                n_vec++;
                if ({stat(k), rdata_w[k][0], rdata_w[k][1]} !== {e, exp_rd[k][0], exp_rd[k][1]}) begin
                    n_err++;
                    $display("FAIL rnd_resp k=%0d s=%0d got stat=%b rd0=%h rd1=%h expected stat=%b rd0=%h rd1=%h",
                             k, s, stat(k), rdata_w[k][0], rdata_w[k][1], e, exp_rd[k][0], exp_rd[k][1]);
                end
                if (g[k] >= 0) req[k][g[k]] = 1'b0;
            end
            @(posedge hclk); #1;
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (stat(k) !== 9'b0) begin
                    n_err++;
                    $display("FAIL rnd_idle k=%0d s=%0d got stat=%b expected 0", k, s, stat(k));
                end
            end
        end
        for (int k = 0; k < 2; k++) req[k] = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_round_robin();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gpcfg_arb.md
GPCFG_ARB -- requirements
Module: gpcfg_arb

Interface
REQ-001 Parameter: PRIO_FIXED, default 0, 0 = round-robin between requesters; 1 = requester 0 always wins a tie.
REQ-002 hclk  input  1  clock; all state changes on the rising edge.
REQ-003 hresetn  input  1  reset; asynchronous, active-low.
REQ-004 m0_req / m1_req  input  1  access request; held with the command fields until the matching ack.
REQ-005 m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-006 m0_addr / m1_addr  input  32  register address.
REQ-007 m0_be / m1_be  input  4  byte enables; used for writes only.
REQ-008 m0_wdata / m1_wdata  input  32  write data.
REQ-009 m0_ack / m1_ack  output  1  one-cycle completion pulse.
REQ-010 m0_rdata / m1_rdata  output  32  read data; valid from the ack cycle until that requester's next read completes.
REQ-011 cfg_wr_en, cfg_rd_en  output  1  strobes to the config register bank.
REQ-012 cfg_byte_en  output  4  byte enables to the bank.
REQ-013 cfg_wr_addr, cfg_rd_addr  output  32  bank addresses; both carry the latched address.
REQ-014 cfg_wdata  output  32  bank write data.
REQ-015 cfg_rdata  input  32  bank read data; combinational from cfg_rd_en and cfg_rd_addr.
REQ-016 busy  output  1  high when the FSM is not IDLE.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP. Transitions: IDLE->ACCESS when any req is high; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-018 Request sampling: req is sampled only in IDLE. A req still high when the FSM returns to IDLE is a new request.
REQ-019 Grant latching: on IDLE->ACCESS, latch the granted requester's we, addr, be and wdata, and latch the grant index gnt.
REQ-020 Single request: when exactly one req is high in IDLE, that requester is granted.
REQ-021 Both requests, PRIO_FIXED=0: grant the requester other than last_gnt. last_gnt updates to gnt on IDLE->ACCESS.
REQ-022 Both requests, PRIO_FIXED=1: requester 0 is always granted.
REQ-023 Bank strobes: in ACCESS only, assert exactly one strobe for exactly one cycle.
- cfg_wr_en = latched we
- cfg_rd_en = not latched we
REQ-024 cfg_byte_en: equals the latched be in a write ACCESS cycle; 4'h0 otherwise.
REQ-025 Bank address/data: cfg_wr_addr, cfg_rd_addr and cfg_wdata hold their latched values outside ACCESS; they do not toggle.
REQ-026 Read capture: in a read ACCESS cycle, register cfg_rdata into the granted requester's rdata at the end of the cycle. A write leaves both rdata registers unchanged.
REQ-027 Ack: in RESP, the granted requester's ack is 1 for exactly one cycle; the other ack stays 0.
REQ-028 Latency and throughput: req high in IDLE at cycle n -> strobe at n+1 -> ack at n+2 -> IDLE at n+3. One access per 3 cycles maximum.
REQ-029 Ungranted request: a requester that loses arbitration keeps req high. It is served on the next IDLE without reissue and receives no ack until served.
REQ-030 Request drop: a req that drops while its access is in flight does not abort the access; the ack is still issued.

Reset
REQ-031 While hresetn=0, and immediately on its assertion (including mid-ACCESS or mid-RESP):
- FSM = IDLE, busy = 0
- all strobes and acks = 0
- cfg_byte_en = 0, cfg_wr_addr = cfg_rd_addr = 0, cfg_wdata = 0
- m0_rdata = m1_rdata = 0
- last_gnt = 1, so requester 0 wins the first tie
- no ack is issued for the interrupted access
REQ-032 After deassertion: the first request is sampled on the first rising edge with hresetn=1.

Verification
REQ-033 Single write: m0 writes addr 0x10, be 4'b0101, wdata 0xAABBCCDD -> cfg_wr_en=1 for one cycle with those values at n+1; m0_ack at n+2; m1_ack stays 0.
REQ-034 Single read: m1 reads addr 0x20, cfg_rdata=0x12345678 -> cfg_rd_en=1 and cfg_byte_en=0 at n+1; m1_rdata=0x12345678 with m1_ack at n+2; m0_rdata unchanged.
REQ-035 Round-robin: both reqs held for 4 accesses (PRIO_FIXED=0) -> grant order m0, m1, m0, m1; acks 3 cycles apart.
REQ-036 Fixed priority: same stimulus with PRIO_FIXED=1 -> m0 served every time; m1 receives no ack while m0_req stays high.
REQ-037 Reset mid-access: assert hresetn=0 during ACCESS of an m0 write -> no m0_ack, all outputs 0; after release, m0 and m1 both request -> m0 granted first.
REQ-038 Back-to-back: m0_req held continuously with m1 idle -> m0 served every 3 cycles; strobe never high in two consecutive cycles.
